shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 118 +++++++++++
 tb/tb_shift_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for a shared,
// LAT-deep left shifter. One operation is in flight at a time: a request is
// granted in IDLE, its operand and amount are registered onto sh_in/sh_ctrl,
// the block waits in HOLD for the shifter result, then presents it in RESP
// until the consumer takes it.
//
// LAT counts the sh_in/sh_ctrl register as the shifter's first stage. The
// result on sh_out is therefore valid in the LAT-th cycle of HOLD. It is
// captured on the edge where cnt runs out, so rsp_valid rises LAT+1 cycles
// after the accept cycle.
module shift_arbiter #(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    output logic        req1_ready,
    output logic [31:0] sh_in,
    output logic [4:0]  sh_ctrl,
    input  logic [31:0] sh_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        grant_id;
    logic        accept;
    logic        capture;

    // The last pending shifter stage is reached when cnt is about to run out.
    assign capture = (state == HOLD) && (cnt <= 4'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> wait for shifter -> hold response until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = HOLD;
            HOLD:    if (capture)   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic: combinational grant and readies, status flags from state.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            // Tie: the requester that was not served last time wins.
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        // Readies are also held low while rst is asserted so nothing looks
        // acceptable while the block is being cleared.
        req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
        req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_id;
        accept     = req0_ready || req1_ready;
        busy       = (state != IDLE);
        rsp_valid  = (state == RESP);
    end

    // Datapath: latch the granted operand, count shifter latency, capture result.
    // sh_in/sh_ctrl only change on accept, since the shifter's control is not
    // pipelined alongside its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            sh_in      <= 32'd0;
            sh_ctrl    <= 5'd0;
            rsp_id     <= 1'b0;
            rsp_data   <= 32'd0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                sh_in      <= grant_id ? req1_data : req0_data;
                sh_ctrl    <= grant_id ? req1_amt  : req0_amt;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= LAT_CNT;
            end else if (state == HOLD) begin
                cnt <= cnt - 4'd1;
                if (capture) begin
                    rsp_data <= sh_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and random stimulus for shift_arbiter, checked
// cycle by cycle against a transaction-level reference model.
module tb_shift_arbiter;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = 32'd0;
    logic [4:0]  req0_amt = 5'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = 32'd0;
    logic [4:0]  req1_amt = 5'd0;
    logic        req1_ready;
    logic [31:0] sh_in;
    logic [4:0]  sh_ctrl;
    logic [31:0] sh_out;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic        busy;

    shift_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .sh_in      (sh_in),
        .sh_ctrl    (sh_ctrl),
        .sh_out     (sh_out),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Shared shifter: the sh_in register is its first stage, LAT-1 more here.
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= sh_in << sh_ctrl;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign sh_out = pipe[LAT-2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one transaction in flight, round-robin on ties.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_last = 1'b1;
    bit          m_id   = 1'b0;
    logic [31:0] m_in   = 32'd0;
    logic [4:0]  m_amt  = 5'd0;
    logic [31:0] m_res  = 32'd0;
    bit          keep_valid = 1'b0;
    bit          saw_rv = 1'b0;
    int          obs_lat = 0;
    bit          id_log[$];
    logic [31:0] data_log[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_sh_in"},   sh_in, 32'd0);
        check32({tag, "_sh_ctrl"}, {27'd0, sh_ctrl}, 32'd0);
        check1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check1({tag, "_rsp_id"},    rsp_id, 1'b0);
        check32({tag, "_rsp_data"}, rsp_data, 32'd0);
        check1({tag, "_busy"},      busy, 1'b0);
        check1({tag, "_req0_rdy"},  req0_ready, 1'b0);
        check1({tag, "_req1_rdy"},  req1_ready, 1'b0);
        $display("reset %s checked", tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs checked before any edge.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        m_busy = 1'b0; m_age = 0; m_last = 1'b1;
        m_in = 32'd0; m_amt = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic step();
        bit e0, e1, erv, hs;
        @(negedge clk);
        if (m_busy) m_age++;
        e0 = !m_busy && req0_valid && (!req1_valid || m_last);
        e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        check1("req0_ready", req0_ready, e0);
        check1("req1_ready", req1_ready, e1);
        check1("ready_excl", req0_ready & req1_ready, 1'b0);
        check1("busy", busy, m_busy);
        check32("sh_in", sh_in, m_in);
        check32("sh_ctrl", {27'd0, sh_ctrl}, {27'd0, m_amt});
        erv = m_busy && (m_age >= LAT + 1);
        check1("rsp_valid", rsp_valid, erv);
        if (rsp_valid && !saw_rv) begin
            saw_rv  = 1'b1;
            obs_lat = m_age;
        end
        if (erv) begin
            check1("rsp_id", rsp_id, m_id);
            check32("rsp_data", rsp_data, m_res);
        end
        hs = erv && rsp_ready;
        if (hs) begin
            id_log.push_back(rsp_id);
            data_log.push_back(rsp_data);
            $display("rsp id=%0d data=%h lat=%0d", rsp_id, rsp_data, obs_lat);
        end
        @(posedge clk);
        #1;
        if (hs) m_busy = 1'b0;
        if (e0 || e1) begin
            m_busy = 1'b1; m_age = 0; m_id = e1; m_last = e1; saw_rv = 1'b0;
            m_in   = e1 ? req1_data : req0_data;
            m_amt  = e1 ? req1_amt  : req0_amt;
            m_res  = m_in << m_amt;
            $display("acc id=%0d data=%h amt=%0d", e1, m_in, m_amt);
            if (e1) begin
                if (keep_valid) begin req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31)); end
                else req1_valid = 1'b0;
            end else begin
                if (keep_valid) begin req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31)); end
                else req0_valid = 1'b0;
            end
        end
    endtask

    // Step until n responses are logged, within a cycle budget.
    task automatic run_until(input int n, input int bound, input string tag);
        int k = 0;
        while (id_log.size() < n && k < bound) begin
            step();
            k++;
        end
        check32(tag, 32'(id_log.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] exp_res;

        // Power-on reset.
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1 << 31 from requester 0, accepted in the first cycle after reset.
        req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 5'd31; rsp_ready = 1'b1;
        id_log.delete(); data_log.delete();
        run_until(1, 20, "t1_done");
        check32("t1_lat", 32'(obs_lat), 32'(LAT + 1));
        check32("t1_data", data_log[0], 32'h8000_0000);
        check1("t1_id", id_log[0], 1'b0);
        step();

        // Tie in the first cycle after reset: requester 0 first, then 1.
        req0_valid = 1'b1; req0_data = 32'hF000_000F; req0_amt = 5'd4;
        req1_valid = 1'b1; req1_data = 32'hDEAD_BEEF; req1_amt = 5'd0;
        rsp_ready  = 1'b1;
        reset_pulse("t2");
        id_log.delete(); data_log.delete();
        run_until(2, 40, "t2_done");
        check1("t2_id0", id_log[0], 1'b0);
        check32("t2_data0", data_log[0], 32'h0000_00F0);
        check1("t2_id1", id_log[1], 1'b1);
        check32("t2_data1", data_log[1], 32'hDEAD_BEEF);

        // Both continuously valid: strict alternation.
        keep_valid = 1'b1;
        req0_valid = 1'b1; req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31));
        req1_valid = 1'b1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31));
        id_log.delete(); data_log.delete();
        run_until(4, 60, "t3_done");
        check1("t3_id0", id_log[0], 1'b0);
        check1("t3_id1", id_log[1], 1'b1);
        check1("t3_id2", id_log[2], 1'b0);
        check1("t3_id3", id_log[3], 1'b1);
        keep_valid = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: response held 10 cycles while requester 1 waits.
        req0_valid = 1'b1; req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31));
        req1_valid = 1'b1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31));
        rsp_ready  = 1'b0;
        saw_rv     = 1'b0;
        id_log.delete(); data_log.delete();
        for (int k = 0; k < 20 && !saw_rv; k++) step();
        check1("t4_rv_seen", saw_rv, 1'b1);
        repeat (10) step();
        rsp_ready = 1'b1;
        run_until(2, 40, "t4_done");
        check1("t4_id0", id_log[0], 1'b0);
        check1("t4_id1", id_log[1], 1'b1);

        // Reset 3 cycles into HOLD: operation abandoned, then normal service.
        req0_valid = 1'b1; req0_data = $urandom; req0_amt = 5'($urandom_range(1, 31));
        rsp_ready  = 1'b1;
        step();
        check1("t5_accepted", busy, 1'b1);
        repeat (3) step();
        reset_pulse("t5");
        id_log.delete(); data_log.delete();
        repeat (12) step();
        check32("t5_no_rsp", 32'(id_log.size()), 32'd0);
        req1_valid = 1'b1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31));
        exp_res    = req1_data << req1_amt;
        run_until(1, 20, "t5_done");
        check1("t5_id", id_log[0], 1'b1);
        check32("t5_data", data_log[0], exp_res);

        // Random traffic with withdrawals and random back-pressure.
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31));
            end else if (req0_valid && $urandom_range(0, 9) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31));
            end else if (req1_valid && $urandom_range(0, 9) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (LAT + 4) step();
        check1("drain_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
